// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
// Shared types and constants for the 1:4 stream demultiplexer and its
// per-channel 2-entry buffers.
//   CH_NUM  : number of output channels
//   sel_t   : channel index carried with each upstream beat
//   occ_e   : per-channel buffer occupancy (EMPTY / ONE / FULL)
//   cnt_t   : per-channel delivered-beat counter type
//   CNT_MAX : saturation value of the beat counters
package stream_demux_pkg;

    localparam int CH_NUM = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    typedef logic [7:0] cnt_t;

    localparam cnt_t CNT_MAX = 8'hFF;

endpackage

// File: rtl/stream_demux_chan_buf.sv
// stream_demux_chan_buf
// Two-entry FIFO holding the beats routed to one output channel. Both the
// head data and the valid/full flags come straight from registers.
// Optional feature macro: STREAM_DEMUX_STATS_EN adds a saturating counter of
// beats delivered to the consumer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write data_in this cycle (caller guarantees !full)
//   data_in     : payload to write
//   pop         : consumer ready; a beat leaves only when valid is also high
//   beat_cnt    : delivered-beat count (STREAM_DEMUX_STATS_EN only)
//   full        : both entries occupied
//   valid       : at least one entry occupied
//   data_out    : payload at the read pointer
module stream_demux_chan_buf
    import stream_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] data_in,
    input  logic         pop,
`ifdef STREAM_DEMUX_STATS_EN
    output cnt_t         beat_cnt,
`endif
    output logic         full,
    output logic         valid,
    output logic [W-1:0] data_out
);

    occ_e               state;
    occ_e               state_nxt;
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0][W-1:0]  mem;
    logic               push_ok;
    logic               pop_ok;

    // pop is the raw consumer ready, so it is qualified with valid here;
    // push is re-qualified with !full so the buffer can never overwrite.
    assign push_ok  = push && (state != FULL);
    assign pop_ok   = pop && (state != EMPTY);

    assign full     = (state == FULL);
    assign valid    = (state != EMPTY);
    assign data_out = mem[rd_ptr];

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy next-state: simultaneous push and pop leaves ONE unchanged.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (push_ok) state_nxt = ONE;
            end
            ONE: begin
                if (push_ok && !pop_ok)      state_nxt = FULL;
                else if (pop_ok && !push_ok) state_nxt = EMPTY;
            end
            FULL: begin
                if (pop_ok) state_nxt = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Storage and pointers; entries are cleared on reset so the head payload
    // reads as zero until the first beat arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

`ifdef STREAM_DEMUX_STATS_EN
    // Delivered-beat counter, saturating rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pop_ok && (beat_cnt != CNT_MAX)) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4
// Routes one valid/ready stream to one of four output channels chosen by the
// per-beat index up_sel. Each channel buffers up to two beats, so a stalled
// channel only blocks upstream while up_sel points at it.
// Optional feature macro: STREAM_DEMUX_STATS_EN adds beat_cnt0..beat_cnt3.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   up_valid / up_ready   : upstream handshake
//   up_data, up_sel       : upstream payload and destination channel
//   beat_cnt0..3          : per-channel delivered-beat counts (stats build)
//   dn_valid / dn_ready   : per-channel downstream handshake (bit i = chan i)
//   dn_data0..3           : per-channel head payload
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    input  sel_t         up_sel,
`ifdef STREAM_DEMUX_STATS_EN
    output cnt_t         beat_cnt0,
    output cnt_t         beat_cnt1,
    output cnt_t         beat_cnt2,
    output cnt_t         beat_cnt3,
`endif
    output logic [3:0]   dn_valid,
    input  logic [3:0]   dn_ready,
    output logic [W-1:0] dn_data0,
    output logic [W-1:0] dn_data1,
    output logic [W-1:0] dn_data2,
    output logic [W-1:0] dn_data3
);

    logic [CH_NUM-1:0] full;
    logic [W-1:0]      dout [CH_NUM];
`ifdef STREAM_DEMUX_STATS_EN
    cnt_t              cnt  [CH_NUM];
`endif

    // Ready depends only on registered fullness and the index, never on
    // dn_ready or up_valid.
    assign up_ready = !full[up_sel];

    for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
        stream_demux_chan_buf #(
            .W (W)
        ) u_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (up_valid && up_ready && (up_sel == sel_t'(i))),
            .data_in  (up_data),
            .pop      (dn_ready[i]),
`ifdef STREAM_DEMUX_STATS_EN
            .beat_cnt (cnt[i]),
`endif
            .full     (full[i]),
            .valid    (dn_valid[i]),
            .data_out (dout[i])
        );
    end

    assign dn_data0 = dout[0];
    assign dn_data1 = dout[1];
    assign dn_data2 = dout[2];
    assign dn_data3 = dout[3];

`ifdef STREAM_DEMUX_STATS_EN
    assign beat_cnt0 = cnt[0];
    assign beat_cnt1 = cnt[1];
    assign beat_cnt2 = cnt[2];
    assign beat_cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_stream_demux_1_4.sv
// tb_stream_demux_1_4
// Self-checking bench for stream_demux_1_4. Expected beats per channel are
// queued as they are issued; a negedge monitor pops and compares each beat
// the DUT hands to a ready consumer.
// Optional feature macro: STREAM_DEMUX_STATS_EN enables the counter checks.
module tb_stream_demux_1_4;

    localparam int W = 4;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         up_valid = 1'b0;
    logic         up_ready;
    logic [W-1:0] up_data  = '0;
    logic [1:0]   up_sel   = '0;
    logic [3:0]   dn_valid;
    logic [3:0]   dn_ready = 4'b1111;
    logic [W-1:0] dn_data0, dn_data1, dn_data2, dn_data3;
`ifdef STREAM_DEMUX_STATS_EN
    logic [7:0]   beat_cnt0, beat_cnt1, beat_cnt2, beat_cnt3;
`endif

    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    logic [W-1:0] expq [4][$];
    logic [W-1:0] dd [4];
    logic [3:0]   hold = '0;
    logic [W-1:0] holdData [4];

    assign dd[0] = dn_data0;
    assign dd[1] = dn_data1;
    assign dd[2] = dn_data2;
    assign dd[3] = dn_data3;

    stream_demux_1_4 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_data   (up_data),
        .up_sel    (up_sel),
`ifdef STREAM_DEMUX_STATS_EN
        .beat_cnt0 (beat_cnt0),
        .beat_cnt1 (beat_cnt1),
        .beat_cnt2 (beat_cnt2),
        .beat_cnt3 (beat_cnt3),
`endif
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .dn_data0  (dn_data0),
        .dn_data1  (dn_data1),
        .dn_data2  (dn_data2),
        .dn_data3  (dn_data3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that
    // accepted the beat. stalls counts negedges seen with up_ready low.
    task automatic applyStimulus(input logic [1:0] sel, input logic [W-1:0] data, output int stalls);
        stalls   = 0;
        up_valid = 1'b1;
        up_sel   = sel;
        up_data  = data;
        @(negedge clk);
        while (!up_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (up_ready) expq[sel].push_back(data);
        else checkOutput("accept_timeout", {31'd0, up_ready}, 32'd1);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
    endtask

    // Monitor: compares every delivered beat and checks held heads stay put.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            hold <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i]) checkOutput($sformatf("stable_ch%0d", i), {28'd0, dd[i]}, {28'd0, holdData[i]});
                hold[i] <= 1'b0;
                if (dn_valid[i] && dn_ready[i]) begin
                    if (expq[i].size() == 0) begin
                        checkOutput($sformatf("unexpected_ch%0d", i), {31'd0, dn_valid[i]}, 32'd0);
                    end else begin
                        e = expq[i].pop_front();
                        checkOutput($sformatf("data_ch%0d", i), {28'd0, dd[i]}, {28'd0, e});
                    end
                end else if (dn_valid[i]) begin
                    hold[i]     <= 1'b1;
                    holdData[i] <= dd[i];
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int st;
        int sum;
        int c0;

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_dn_valid", {28'd0, dn_valid}, 32'h0);
        checkOutput("reset_up_ready", {31'd0, up_ready}, 32'h1);
        checkOutput("reset_dn_data0", {28'd0, dn_data0}, 32'h0);
        checkOutput("reset_dn_data1", {28'd0, dn_data1}, 32'h0);
        checkOutput("reset_dn_data2", {28'd0, dn_data2}, 32'h0);
        checkOutput("reset_dn_data3", {28'd0, dn_data3}, 32'h0);
`ifdef STREAM_DEMUX_STATS_EN
        checkOutput("reset_cnt0", {24'd0, beat_cnt0}, 32'h0);
        checkOutput("reset_cnt3", {24'd0, beat_cnt3}, 32'h0);
`endif
        @(posedge clk);
        #1;

        // Single beat to channel 2, consumed on the following edge.
        applyStimulus(2'd2, 4'hA, st);
        checkOutput("single_stalls", st, 0);
        @(negedge clk);
        checkOutput("single_dn_valid", {28'd0, dn_valid}, 32'h4);
        checkOutput("single_dn_data2", {28'd0, dn_data2}, 32'hA);
        @(negedge clk);
        checkOutput("single_drained", {28'd0, dn_valid}, 32'h0);
        @(posedge clk);
        #1;

        // Channel 1 stalled: two beats fit, then another channel still flows.
        dn_ready = 4'b1101;
        applyStimulus(2'd1, 4'h1, st);
        checkOutput("ch1_b1_stalls", st, 0);
        applyStimulus(2'd1, 4'h2, st);
        checkOutput("ch1_b2_stalls", st, 0);
        applyStimulus(2'd3, 4'h5, st);
        checkOutput("ch3_bypass_stalls", st, 0);
        @(negedge clk);
        checkOutput("bypass_dn_valid", {28'd0, dn_valid}, 32'hA);
        checkOutput("bypass_dn_data3", {28'd0, dn_data3}, 32'h5);
        checkOutput("ch1_head", {28'd0, dn_data1}, 32'h1);
        @(posedge clk);
        #1;

        // Third beat to the full channel waits until its consumer is released.
        fork
            applyStimulus(2'd1, 4'h3, st);
            begin
                @(negedge clk);
                checkOutput("ch1_full_up_ready", {31'd0, up_ready}, 32'h0);
                repeat (2) @(negedge clk);
                @(posedge clk);
                #1;
                dn_ready = 4'b1111;
            end
        join
        checkOutput("ch1_b3_stalls", st, 4);
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back beats to channel 0.
        sum = 0;
        c0  = cyc;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'd0, 4'(i * 7 + 3), st);
            sum += st;
        end
        checkOutput("stream_stalls", sum, 0);
        checkOutput("stream_cycles", cyc - c0, 16);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle with every channel holding data.
        dn_ready = 4'b0000;
        applyStimulus(2'd0, 4'h9, st);
        applyStimulus(2'd1, 4'h6, st);
        applyStimulus(2'd2, 4'hC, st);
        applyStimulus(2'd3, 4'hF, st);
        @(negedge clk);
        checkOutput("prereset_dn_valid", {28'd0, dn_valid}, 32'hF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_dn_valid", {28'd0, dn_valid}, 32'h0);
        checkOutput("async_reset_dn_data1", {28'd0, dn_data1}, 32'h0);
        foreach (expq[i]) expq[i].delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        dn_ready = 4'b1111;
        @(posedge clk);
        #1;
        checkOutput("postreset_dn_valid", {28'd0, dn_valid}, 32'h0);

        // Counter exercise: 3 pops on channel 2, 300 on channel 0.
        for (int i = 0; i < 3; i++) applyStimulus(2'd2, 4'(i + 1), st);
        for (int i = 0; i < 300; i++) applyStimulus(2'd0, 4'(i), st);
        repeat (4) @(posedge clk);
        #1;
`ifdef STREAM_DEMUX_STATS_EN
        checkOutput("cnt0_saturated", {24'd0, beat_cnt0}, 32'd255);
        checkOutput("cnt2", {24'd0, beat_cnt2}, 32'd3);
        checkOutput("cnt1", {24'd0, beat_cnt1}, 32'd0);
`endif
        checkOutput("final_dn_valid", {28'd0, dn_valid}, 32'h0);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("leftover_ch%0d", i), expq[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
